// File: rtl/mux_demux_router.sv
// Registered 1-to-NCH demultiplexer: valid/ready beats land in per-channel holding
// registers, each with an ack-cleared valid flag, plus a saturating transfer counter.
module mux_demux_router #(
  parameter int unsigned NCH = 32,
  parameter int unsigned DW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        in_sel,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ack,
  output logic [7:0]        xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e         state_q [NCH];
  ch_state_e         state_d [NCH];
  logic [NCH*DW-1:0] data_q;
  logic [NCH*DW-1:0] data_d;
  logic [7:0]        count_q;
  logic [7:0]        count_d;
  logic [NCH-1:0]    hit;
  logic              accept;

  // An ack on the target channel frees its slot in the same cycle.
  assign in_ready = !flush && (!out_valid[in_sel] || out_ack[in_sel]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      hit[i] = accept && (32'(in_sel) == i);
    end
  end

  always_comb begin
    data_d = data_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        EMPTY: begin
          if (hit[i]) state_d[i] = FULL;
        end
        FULL: begin
          // Accept wins over a coincident ack; flush wins over everything.
          if (flush)                    state_d[i] = EMPTY;
          else if (!hit[i] && out_ack[i]) state_d[i] = EMPTY;
        end
      endcase
      if (hit[i]) data_d[i*DW +: DW] = in_data;
    end
  end

  assign count_d = (accept && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= EMPTY;
      end
      data_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
      end
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_data   = data_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_mux_demux_router.sv
// Self-checking bench for mux_demux_router: directed vector table, randomized
// traffic against a behavioural channel model, counter saturation and async reset.
module tb_mux_demux_router;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_sel;
  logic [1:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic [63:0] out_data;
  logic [31:0] out_valid;
  logic [31:0] out_ack;
  logic [7:0]  xfer_count;

  mux_demux_router #(.NCH(32), .DW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: one valid bit and one data word per channel.
  bit         m_valid [32];
  logic [1:0] m_data  [32];
  int         m_cnt;

  typedef struct {
    logic        vld;
    logic [4:0]  sel;
    logic [1:0]  dat;
    logic        fl;
    logic [31:0] ack;
    logic        exp_rdy;
    logic [31:0] exp_valid;
    logic [63:0] exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic vld, input logic [4:0] sel, input logic [1:0] dat,
                              input logic fl, input logic [31:0] ack, input logic rdy,
                              input logic [31:0] ev, input logic [63:0] ed, input logic [7:0] ec);
    vec_t v;
    v.vld = vld; v.sel = sel; v.dat = dat; v.fl = fl; v.ack = ack;
    v.exp_rdy = rdy; v.exp_valid = ev; v.exp_data = ed; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_valid_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [63:0] m_data_vec();
    logic [63:0] v;
    for (int i = 0; i < 32; i++) v[2*i +: 2] = m_data[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 2'b00;
    end
    m_cnt = 0;
  endtask

  // Applies the current inputs for one clock edge, keeping the model in step.
  task automatic cycle(input bit chk);
    bit take;
    take = in_valid && !flush && (!m_valid[in_sel] || out_ack[in_sel]);
    if (chk) check("model_ready", {63'd0, in_ready}, {63'd0, (!flush && (!m_valid[in_sel] || out_ack[in_sel]))});
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) if (out_ack[i]) m_valid[i] = 1'b0;
      if (take) begin
        m_valid[in_sel] = 1'b1;
        m_data[in_sel]  = in_data;
        if (m_cnt < 255) m_cnt++;
      end
    end
    #1;
    if (chk) begin
      check("model_valid", {32'd0, out_valid}, {32'd0, m_valid_vec()});
      check("model_data", out_data, m_data_vec());
      check("model_count", {56'd0, xfer_count}, 64'(m_cnt));
    end
  endtask

  initial begin
    bit stalled;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; flush = 1'b0; out_ack = '0;
    model_clear();
    #1;
    check("reset_valid", {32'd0, out_valid}, 64'd0);
    check("reset_data", out_data, 64'd0);
    check("reset_count", {56'd0, xfer_count}, 64'd0);
    check("reset_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    tbl[0]  = mk(1, 5,  2'b10, 0, 32'h0,          1, 32'h0000_0020, 64'h0000_0000_0000_0800, 1);
    tbl[1]  = mk(1, 5,  2'b01, 0, 32'h0,          0, 32'h0000_0020, 64'h0000_0000_0000_0800, 1);
    tbl[2]  = mk(1, 5,  2'b01, 0, 32'h0000_0020,  1, 32'h0000_0020, 64'h0000_0000_0000_0400, 2);
    tbl[3]  = mk(1, 0,  2'b11, 0, 32'h0,          1, 32'h0000_0021, 64'h0000_0000_0000_0403, 3);
    tbl[4]  = mk(1, 31, 2'b01, 0, 32'h0,          1, 32'h8000_0021, 64'h4000_0000_0000_0403, 4);
    tbl[5]  = mk(1, 30, 2'b10, 0, 32'h0,          1, 32'hC000_0021, 64'h6000_0000_0000_0403, 5);
    tbl[6]  = mk(0, 30, 2'b10, 0, 32'hC000_0021,  1, 32'h0000_0000, 64'h6000_0000_0000_0403, 5);
    tbl[7]  = mk(1, 7,  2'b01, 0, 32'h0,          1, 32'h0000_0080, 64'h6000_0000_0000_4403, 6);
    tbl[8]  = mk(1, 3,  2'b01, 0, 32'h0,          1, 32'h0000_0088, 64'h6000_0000_0000_4443, 7);
    tbl[9]  = mk(1, 3,  2'b10, 0, 32'h0000_0288,  1, 32'h0000_0008, 64'h6000_0000_0000_4483, 8);
    tbl[10] = mk(1, 1,  2'b01, 0, 32'h0,          1, 32'h0000_000A, 64'h6000_0000_0000_4487, 9);
    tbl[11] = mk(1, 2,  2'b11, 0, 32'h0,          1, 32'h0000_000E, 64'h6000_0000_0000_44B7, 10);
    tbl[12] = mk(1, 4,  2'b10, 0, 32'h0,          1, 32'h0000_001E, 64'h6000_0000_0000_46B7, 11);
    tbl[13] = mk(1, 8,  2'b11, 1, 32'h0,          0, 32'h0000_0000, 64'h6000_0000_0000_46B7, 11);
    tbl[14] = mk(0, 8,  2'b11, 0, 32'h0,          1, 32'h0000_0000, 64'h6000_0000_0000_46B7, 11);

    for (int r = 0; r < 15; r++) begin
      in_valid = tbl[r].vld; in_sel = tbl[r].sel; in_data = tbl[r].dat;
      flush = tbl[r].fl; out_ack = tbl[r].ack;
      #1;
      check($sformatf("vec%0d_ready", r), {63'd0, in_ready}, {63'd0, tbl[r].exp_rdy});
      cycle(1'b0);
      check($sformatf("vec%0d_valid", r), {32'd0, out_valid}, {32'd0, tbl[r].exp_valid});
      check($sformatf("vec%0d_data", r), out_data, tbl[r].exp_data);
      check($sformatf("vec%0d_count", r), {56'd0, xfer_count}, {56'd0, tbl[r].exp_cnt});
    end

    // Randomized traffic; a stalled beat is held stable until taken.
    stalled = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        in_data  = 2'($urandom);
      end
      out_ack = $urandom & $urandom;
      flush   = ($urandom_range(0, 24) == 0);
      #1;
      stalled = in_valid && !in_ready;
      cycle(1'b1);
    end

    // Saturation: consumer acks every channel every cycle.
    flush = 1'b0; out_ack = '1; in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      in_sel  = 5'($urandom_range(0, 31));
      in_data = 2'($urandom);
      #1;
      cycle(1'b1);
    end
    check("saturated_count", {56'd0, xfer_count}, 64'd255);

    // Asynchronous reset between edges.
    in_valid = 1'b1; in_sel = 5'd9; in_data = 2'b11; out_ack = '0;
    cycle(1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", {32'd0, out_valid}, 64'd0);
    check("async_rst_data", out_data, 64'd0);
    check("async_rst_count", {56'd0, xfer_count}, 64'd0);
    check("async_rst_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b1;
    #1;
    check("async_rst_flush_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_demux_router.md
# mux_demux_router

Registered 1-to-32 demultiplexer for 2-bit data: the write-side counterpart of the 32-input, 2-bit select mux. It accepts one (select, data) beat per cycle over a valid/ready handshake and deposits the data into one of 32 output holding registers. Each register has its own valid flag, which the downstream consumer clears by acknowledging it. A saturating transfer counter supports debug.

## Interface
Parameters:
- `NCH`, default 32: number of output channels. The select width is fixed at 5; `NCH` must equal 32.
- `DW`, default 2: data width per channel.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  the input beat is present.
- `in_sel`  input  5  target channel, 0..31. All 32 codes are legal.
- `in_data`  input  2  payload.
- `in_ready`  output  1  the router can accept the beat this cycle.
- `flush`  input  1  synchronous clear of all channel valid flags.
- `out_data`  output  64  channel i occupies bits [2i+1:2i].
- `out_valid`  output  32  bit i is set when channel i holds unconsumed data.
- `out_ack`  input  32  bit i means the consumer takes channel i this cycle.
- `xfer_count`  output  8  number of accepted beats since reset, saturating.

## Operation
- **Accept.** A beat is accepted when `in_valid && in_ready`. On that clock edge:
  - `out_data[2*in_sel +: 2]` is set to `in_data`.
  - `out_valid[in_sel]` is set to 1.
  - `xfer_count` increments, holding at 255.
- **Ready.** `in_ready` is combinational: `!flush && (!out_valid[in_sel] || out_ack[in_sel])`.
  - An ack on the target channel in the same cycle frees that slot for a new beat.
  - `in_ready` is evaluated even when `in_valid` = 0.
- **Consume.** When `out_valid[i] && out_ack[i]` and there is no accept to channel i on that edge, `out_valid[i]` is cleared.
  - If an accept to channel i coincides with its ack, `out_valid[i]` stays 1 and `out_data` for channel i takes the new value.
  - `out_ack[i]` while `out_valid[i]` = 0 is ignored.
- **Independence.** Channels are independent. Acks on any number of channels are processed in the same cycle as an accept to a different channel.
- **Flush.** While `flush` = 1:
  - `in_ready` = 0 and no beat is accepted.
  - All `out_valid` bits clear on the edge.
  - `out_data` retains its contents and `xfer_count` is unchanged.
  - Flush overrides acks, which become irrelevant.
- **Data hold.** `out_data` for a channel changes only on an accept to that channel. It holds its value after an ack or a flush.
- **Counter.** `xfer_count` saturates at 8'hFF and is cleared only by `rst`.
- **Per-channel state** is a 2-state machine: EMPTY (`valid` = 0) and FULL (`valid` = 1).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on ack without accept, or on flush.
  - FULL to FULL on accept with ack.
  - EMPTY to EMPTY otherwise.

## Timing
- **Reset.** Asserting `rst` immediately forces:
  - `out_valid` = 0
  - `out_data` = 0
  - `xfer_count` = 0
  - `in_ready` then evaluates to 1, unless `flush` = 1.
- **Reset mid-operation.** All pending channel data is discarded. There is no partial-beat state.
- **Latency.**
  - An accepted beat is visible on `out_data` and `out_valid` one cycle after the accepting edge.
  - `in_ready` responds combinationally to `in_sel`, `out_ack` and `flush`, with no register in that path.
- **Handshake rules.**
  - The producer must hold `in_sel` and `in_data` stable while `in_valid` = 1 and `in_ready` = 0.
  - The router does not require `in_valid` to stay high.
- **Throughput.**
  - One beat per cycle to distinct channels.
  - To the same channel, one beat per cycle only if the consumer acks every cycle; otherwise it stalls until the ack.
- **Counter.** At 255, an accept leaves the count at 255. Wrap-around never occurs.

## Test plan
- **Reset and basic accept.** Assert `rst`, release it, then send sel=5, data=2'b10, valid=1.
  - `in_ready` = 1.
  - Next cycle: `out_valid` = 32'h0000_0020, `out_data[11:10]` = 2'b10, `xfer_count` = 1.
- **Backpressure and release.**
  - With channel 5 FULL and no ack, present sel=5, data=2'b01: `in_ready` = 0 and channel 5 keeps 2'b10.
  - Assert `out_ack[5]` in the same cycle: `in_ready` = 1; next cycle channel 5 = 2'b01 with valid still 1.
- **Edge channels.** Write sel=0 data=2'b11, then sel=31 data=2'b01, then sel=30 data=2'b10.
  - `out_valid` = 32'hC000_0001.
  - `out_data[63:60]` = 4'b0110 and `out_data[1:0]` = 2'b11.
  - Ack all three: `out_valid` = 0 and the data is held.
- **Simultaneous events.** Accept to channel 3 while acking channels 3, 7 (FULL) and 9 (EMPTY).
  - Next cycle: bit 3 = 1, bit 7 = 0, bit 9 = 0.
- **Flush.** With channels 1, 2 and 4 FULL, assert `flush` together with `in_valid` (sel=8).
  - `in_ready` = 0.
  - Next cycle: `out_valid` = 0, channel 8 is not written, `xfer_count` is unchanged, and `out_data` is unchanged.
- **Saturation and async reset.** Accept 300 beats with the consumer always acking: `xfer_count` = 255.
  - Assert `rst` between clock edges: all outputs are 0 before the next edge.
